// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op/state types and funct3 decode helpers for the iterative M-extension unit
package muldiv_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // MUL low half is sign-agnostic, so treating it as signed*signed is harmless
  function automatic logic is_signed_a(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_div(input op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_hi(input op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic is_rem(input op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// rtl/muldiv_signfix.sv - sign correction and result select applied to the magnitude accumulator
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        op,
  input  logic              sign_a,
  input  logic              sign_b,
  input  logic              b_zero,
  input  logic [2*XLEN-1:0] acc,
  output logic [XLEN-1:0]   result
);

  op_e               op_q;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  assign op_q = op_e'(op);

  // divide leaves quotient in the low half and remainder in the high half
  always_comb begin
    prod = (sign_a ^ sign_b) ? -acc : acc;
    quo  = ((sign_a ^ sign_b) && !b_zero) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (is_div(op_q)) begin
      result = is_rem(op_q) ? rem : quo;
    end else begin
      result = is_hi(op_q) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end
  end

endmodule

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative RV32M multiply/divide unit; MULDIV_FAST_EN enables the zero-operand early-out
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  state_e            state;
  state_e            state_nxt;
  op_e               op_in;
  op_e               op_r;
  logic              sign_a;
  logic              sign_b;
  logic              b_zero;
  logic              loaded;
  logic [XLEN-1:0]   a_r;
  logic [XLEN-1:0]   b_r;
  logic [2*XLEN-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              fast_hit;
  logic              last_iter;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [XLEN-1:0]   fix_result;

  assign op_in     = op_e'(funct3);
  assign accept    = start && (state == IDLE || state == DONE);
  assign last_iter = loaded && (cnt == CNT_W'(XLEN - 1));

`ifdef MULDIV_FAST_EN
  logic [XLEN-1:0] fast_result;

  always_comb begin
    fast_hit    = (a == '0) || (b == '0);
    fast_result = '0;
    if (b == '0) begin
      if (op_in inside {OP_DIV, OP_DIVU}) begin
        fast_result = '1;
      end else if (is_rem(op_in)) begin
        fast_result = a;
      end
    end
  end
`else
  assign fast_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_nxt = fast_hit ? DONE : CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC:    if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC) || (state == FIX);
    done = (state == DONE);
  end

  // multiply shifts right adding the multiplicand; divide shifts left restoring
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? b_r : {XLEN{1'b0}})};
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_r};
  end

  // first CALC cycle only converts the latched operands to magnitudes, keeping
  // the negation off the start path; XLEN iterations follow
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r   <= OP_MUL;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
      loaded <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (accept) begin
      op_r   <= op_in;
      a_r    <= a;
      b_r    <= b;
      sign_a <= is_signed_a(op_in) && a[XLEN-1];
      sign_b <= is_signed_b(op_in) && b[XLEN-1];
      b_zero <= (b == '0);
      loaded <= 1'b0;
      cnt    <= '0;
`ifdef MULDIV_FAST_EN
      if (fast_hit) begin
        result <= fast_result;
      end
`endif
    end else if (state == CALC) begin
      if (!loaded) begin
        acc    <= {{XLEN{1'b0}}, (sign_a ? -a_r : a_r)};
        b_r    <= sign_b ? -b_r : b_r;
        loaded <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
        if (is_div(op_r)) begin
          if (!div_diff[XLEN]) begin
            acc <= {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
          end else begin
            acc <= {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
          end
        end else begin
          acc <= {mul_sum, acc[XLEN-1:1]};
        end
      end
    end else if (state == FIX) begin
      result <= fix_result;
    end
  end

  muldiv_signfix #(.XLEN(XLEN)) u_signfix (
    .op     (op_r),
    .sign_a (sign_a),
    .sign_b (sign_b),
    .b_zero (b_zero),
    .acc    (acc),
    .result (fix_result)
  );

endmodule

// File: tb/tb_muldiv_iter.sv
// tb/tb_muldiv_iter.sv - scoreboard bench for muldiv_iter
`timescale 1ns/1ps
module tb_muldiv_iter;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  muldiv_iter #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    int          lat;
    int          t0;
  } item_t;

  item_t sb[$];
  item_t mon_it;
  int    n_chk = 0;
  int    n_pass = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy;
    logic [63:0] ux, uy, p;
    logic [31:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (f)
      3'd0: begin p = ux * uy; r = p[31:0]; end
      3'd1: begin p = sx * sy; r = p[63:32]; end
      3'd2: begin p = sx * longint'(uy); r = p[63:32]; end
      3'd3: begin p = ux * uy; r = p[63:32]; end
      3'd4: r = (y == 0) ? 32'hFFFF_FFFF : (x == MIN && y == 32'hFFFF_FFFF) ? MIN : 32'(sx / sy);
      3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: r = (y == 0) ? x : (x == MIN && y == 32'hFFFF_FFFF) ? 32'd0 : 32'(sx % sy);
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y);
`ifdef MULDIV_FAST_EN
    return (x == 0 || y == 0) ? 1 : XLEN + 2;
`else
    return XLEN + 2;
`endif
  endfunction

  // result is compared when done shows, away from the driver's #1 slot
  always @(posedge clk) begin
    #3;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        mon_it = sb.pop_front();
        check({mon_it.tag, "_res"}, 64'(mon_it.exp), 64'(result));
        check({mon_it.tag, "_lat"}, 64'(cyc - mon_it.t0), 64'(mon_it.lat));
      end
    end
  end

  task automatic issue(input string tag, input logic [2:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp);
    item_t it;
    funct3 = f;
    a      = x;
    b      = y;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    it.tag = tag;
    it.exp = exp;
    it.lat = exp_lat(x, y);
    it.t0  = cyc;
    sb.push_back(it);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      check({tag, "_timeout"}, 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input string tag, input logic [2:0] f, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] exp);
    issue(tag, f, x, y, exp);
    drain(tag);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return MIN;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [2:0]  f;
    logic [31:0] x, y;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run("mulh_min", 3'd1, MIN, MIN, 32'h4000_0000);
    run("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run("divu_min_3", 3'd5, MIN, 32'd3, 32'h2AAA_AAAA);
    run("div_5_0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run("rem_5_0", 3'd6, 32'd5, 32'd0, 32'd5);
    run("div_min_m1", 3'd4, MIN, 32'hFFFF_FFFF, MIN);
    run("rem_min_m1", 3'd6, MIN, 32'hFFFF_FFFF, 32'd0);
    run("remu_9_0", 3'd7, 32'd9, 32'd0, 32'd9);
    run("mul_0_x", 3'd0, 32'd0, 32'd1234, 32'd0);

    issue("ignore", 3'd5, 32'd100, 32'd7, 32'd14);
    repeat (5) begin @(posedge clk); #1; end
    funct3 = 3'd0; a = 32'd3; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drain("ignore");

    issue("b2b1", 3'd0, 32'd6, 32'd7, 32'd42);
    n = 0;
    while (!done && n < 100) begin @(posedge clk); #1; n++; end
    if (!done) check("b2b_wait", 64'(done), 64'd1);
    issue("b2b2", 3'd4, 32'd100, 32'hFFFF_FFFB, 32'hFFFF_FFEC);
    drain("b2b2");

    issue("abort", 3'd0, 32'd5, 32'd5, 32'd25);
    repeat (6) begin @(posedge clk); #1; end
    reset = 1'b1;
    sb.delete(sb.size() - 1);
    @(posedge clk); #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    run("mul_3_4", 3'd0, 32'd3, 32'd4, 32'd12);

    for (int i = 0; i < 24; i++) begin
      f = 3'($urandom_range(0, 7));
      x = pick();
      y = pick();
      run($sformatf("rnd%0d_f%0d", i, f), f, x, y, ref_op(f, x, y));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
